// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and bit-timing helpers
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_START_BIT, ST_DATA_BITS, ST_STOP_BIT} uart_state_e;
  function automatic int bit_cycles(input int sys_clock, input int baudrate);
    return sys_clock / baudrate + 1;
  endfunction
  function automatic int half_cycles(input int sys_clock, input int baudrate);
    return bit_cycles(sys_clock, baudrate) / 2;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser, falling-edge detect and sampled line bit
//   clk_i, rst_i : clock, sync active-high reset (flops preset to idle-high)
//   rx_i         : asynchronous serial line
//   fall_o       : synchronised line went 1->0 this cycle
//   bit_o        : sample value; 2-of-3 majority of the last three synchronised
//                  values when UART_RX_MAJORITY_EN is defined, else the
//                  synchronised line itself
module uart_rx_sync import uart_pkg::*; (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic fall_o,
  output logic bit_o
);
`ifdef UART_RX_MAJORITY_EN
  logic [3:0] sync_q;
  always_ff @(posedge clk_i) sync_q <= rst_i ? '1 : {sync_q[2:0], rx_i};
  assign bit_o = (sync_q[1] & sync_q[2]) | (sync_q[1] & sync_q[3]) | (sync_q[2] & sync_q[3]);
`else
  logic [2:0] sync_q;
  always_ff @(posedge clk_i) sync_q <= rst_i ? '1 : {sync_q[1:0], rx_i};
  assign bit_o = sync_q[1];
`endif
  assign fall_o = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with valid strobe and framing-error flag
//   i_SysClock, i_Reset : clock, sync active-high reset
//   i_RxSerial          : asynchronous serial input, idle high
//   o_RxByte            : last good byte, held until the next good byte
//   o_RxValid           : one-cycle pulse, o_RxByte updated
//   o_FrameErr          : one-cycle pulse, stop bit sampled low
//   o_Busy              : receiver not idle
//   UART_RX_MAJORITY_EN : 2-of-3 majority sampling, decisions one clock later
module uart_rx import uart_pkg::*; #(
  parameter int SYS_CLOCK     = 50000000,
  parameter int UART_BAUDRATE = 115200
) (
  input  logic                 i_SysClock,
  input  logic                 i_Reset,
  input  logic                 i_RxSerial,
  output logic [DATA_BITS-1:0] o_RxByte,
  output logic                 o_RxValid,
  output logic                 o_FrameErr,
  output logic                 o_Busy
);
  localparam int BIT_CYCLES  = bit_cycles(SYS_CLOCK, UART_BAUDRATE);
  localparam int HALF_CYCLES = half_cycles(SYS_CLOCK, UART_BAUDRATE);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_AT = HALF_CYCLES + 1;
`else
  localparam int START_AT = HALF_CYCLES;
`endif
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, byte_q, byte_d;
  logic                 valid_q, valid_d, err_q, err_d;
  logic                 fall, smp;
  uart_rx_sync u_sync (
    .clk_i (i_SysClock),
    .rst_i (i_Reset),
    .rx_i  (i_RxSerial),
    .fall_o(fall),
    .bit_o (smp)
  );
  // Only the start sample moves with the majority window; data/stop samples
  // are counted from it, so they follow automatically.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        state_d = fall ? ST_START_BIT : ST_IDLE;
      end
      ST_START_BIT: if (cnt_q == CW'(START_AT)) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = smp ? ST_IDLE : ST_DATA_BITS;
      end
      ST_DATA_BITS: if (cnt_q == CW'(BIT_CYCLES - 1)) begin
        cnt_d   = '0;
        shift_d = {smp, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == BW'(DATA_BITS - 1) ? ST_STOP_BIT : ST_DATA_BITS;
      end
      ST_STOP_BIT: if (cnt_q == CW'(BIT_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        valid_d = smp;
        err_d   = ~smp;
        byte_d  = smp ? shift_q : byte_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_SysClock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign o_RxByte   = byte_q;
  assign o_RxValid  = valid_q;
  assign o_FrameErr = err_q;
  assign o_Busy     = state_q != ST_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a waveform-level frame model
module tb_uart_rx;
  localparam int BIT  = 1000 / 100 + 1;
  localparam int HALF = BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  typedef struct packed {logic err; logic [7:0] data; int cyc;} ev_t;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] rx_byte;
  logic rx_valid, frame_err, busy;
  int n_checks = 0, n_pass = 0;
  logic wave[$];
  ev_t exp_q[$], obs_q[$];
  int exp_busy, obs_busy;
  logic both;
  logic [7:0] exp_byte = 8'h00;
  uart_rx #(.SYS_CLOCK(1000), .UART_BAUDRATE(100)) dut (
    .i_SysClock(clk),
    .i_Reset   (rst),
    .i_RxSerial(rx),
    .o_RxByte  (rx_byte),
    .o_RxValid (rx_valid),
    .o_FrameErr(frame_err),
    .o_Busy    (busy)
  );
  always #5 clk = ~clk;
  task automatic add(input logic v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask
  task automatic add_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = wave.size();
    add(1'b0, BIT);
    for (int k = 0; k < 8; k++) add(b[k], BIT);
    add(stop, BIT);
  endtask
  // Line value as the receiver judges it at line index d.
  function automatic logic smp(input int d);
    return OFF != 0 ? (wave[d-2] & wave[d-1]) | (wave[d-2] & wave[d]) | (wave[d-1] & wave[d]) : wave[d];
  endfunction
  // Frame-level reference: a 1->0 step at line index t0 is a start edge; the
  // start is judged HALF+1 line cycles later (edge register adds one), each
  // further bit one BIT later. The strobe is seen two cycles after the stop
  // judgement; a new start edge is looked for from the cycle after it.
  task automatic model();
    int i, t0, d;
    logic [7:0] sh;
    exp_q = {};
    exp_busy = 0;
    i = 1;
    while (i < wave.size()) begin
      if (wave[i-1] && !wave[i]) begin
        t0 = i;
        d = t0 + 1 + HALF + OFF;
        if (!smp(d)) begin
          for (int k = 0; k < 8; k++) sh[k] = smp(d + (k + 1) * BIT);
          d += 9 * BIT;
          if (smp(d)) exp_byte = sh;
          exp_q.push_back('{!smp(d), exp_byte, d + 2});
        end
        exp_busy += d - t0;
        i = d + 1;
      end else i++;
    end
  endtask
  task automatic play();
    obs_q = {};
    obs_busy = 0;
    both = 1'b0;
    for (int i = 0; i < wave.size(); i++) begin
      rx = wave[i];
      @(posedge clk);
      #1;
      if (rx_valid || frame_err) obs_q.push_back('{frame_err, rx_byte, i});
      both |= rx_valid & frame_err;
      obs_busy += int'(busy);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_byte, rx_valid, frame_err, busy} !== 11'h0)
      $display("FAIL reset_state: got byte=%h v=%b e=%b busy=%b required all zero", rx_byte, rx_valid, frame_err, busy);
    else n_pass++;
    rst = 1'b0;
    exp_byte = 8'h00;
  endtask
  task automatic test_single();
    int t0;
    wave = {};
    add(1'b1, 4);
    add_frame(8'hA5, 1'b1, t0);
    add(1'b1, 6);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL single_ev%0d: got %p required %p", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (rx_byte !== 8'hA5 || frame_err !== 1'b0) $display("FAIL single_byte: got %h err=%b required a5 err=0", rx_byte, frame_err);
    else n_pass++;
    n_checks++;
    if (obs_busy !== exp_busy) $display("FAIL single_busy: got %0d required %0d", obs_busy, exp_busy);
    else n_pass++;
  endtask
  task automatic test_glitch();
    wave = {};
    add(1'b1, 4);
    add(1'b0, 3);
    add(1'b1, 12);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL glitch_events: got %0d required 0", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_busy !== 1 + HALF + OFF) $display("FAIL glitch_busy: got %0d required %0d", obs_busy, 1 + HALF + OFF);
    else n_pass++;
  endtask
  task automatic test_frame_err();
    int t0;
    wave = {};
    add(1'b1, 4);
    add_frame(8'h3C, 1'b0, t0);
    add(1'b1, 6);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL ferr_event: got n=%0d %p required %p", obs_q.size(), obs_q[0], exp_q[0]);
    else n_pass++;
    n_checks++;
    if (obs_q[0].err !== 1'b1 || rx_byte !== 8'hA5)
      $display("FAIL ferr_hold: got err=%b byte=%h required err=1 byte=a5", obs_q[0].err, rx_byte);
    else n_pass++;
    n_checks++;
    if (obs_busy !== exp_busy) $display("FAIL ferr_busy: got %0d required %0d", obs_busy, exp_busy);
    else n_pass++;
  endtask
  task automatic test_back_to_back();
    int t0;
    wave = {};
    add(1'b1, 4);
    add_frame(8'h00, 1'b1, t0);
    add_frame(8'hFF, 1'b1, t0);
    add(1'b1, 6);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== 2) $display("FAIL b2b_count: got %0d required 2", obs_q.size());
    else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL b2b_ev%0d: got %p required %p", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (rx_byte !== 8'hFF || both !== 1'b0) $display("FAIL b2b_final: got byte=%h both=%b required ff 0", rx_byte, both);
    else n_pass++;
  endtask
  task automatic test_reset_mid();
    int t0;
    wave = {};
    add(1'b1, 4);
    add(1'b0, BIT);
    for (int k = 0; k < 4; k++) add(k == 0, BIT);
    add(1'b0, HALF);
    play();
    n_checks++;
    if (obs_q.size() !== 0 || busy !== 1'b1) $display("FAIL rmid_before: got n=%0d busy=%b required 0 1", obs_q.size(), busy);
    else n_pass++;
    rst = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({rx_byte, rx_valid, frame_err, busy} !== 11'h0)
      $display("FAIL rmid_reset: got byte=%h v=%b e=%b busy=%b required all zero", rx_byte, rx_valid, frame_err, busy);
    else n_pass++;
    rst = 1'b0;
    exp_byte = 8'h00;
    wave = {};
    add(1'b1, 4);
    add_frame(8'h5A, 1'b1, t0);
    add(1'b1, 6);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL rmid_next: got n=%0d %p required %p", obs_q.size(), obs_q[0], exp_q[0]);
    else n_pass++;
    n_checks++;
    if (rx_byte !== 8'h5A) $display("FAIL rmid_byte: got %h required 5a", rx_byte);
    else n_pass++;
  endtask
  task automatic test_majority();
    int t0;
    logic [7:0] want;
    wave = {};
    add(1'b1, 4);
    add_frame(8'h55, 1'b1, t0);
    wave[t0 + 1 + HALF + 3 * BIT] = ~wave[t0 + 1 + HALF + 3 * BIT];
    add(1'b1, 6);
    model();
    play();
`ifdef UART_RX_MAJORITY_EN
    want = 8'h55;
`else
    want = 8'h51;
`endif
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0])
      $display("FAIL maj_event: got n=%0d %p required %p", obs_q.size(), obs_q[0], exp_q[0]);
    else n_pass++;
    n_checks++;
    if (rx_byte !== want) $display("FAIL maj_byte: got %h required %h", rx_byte, want);
    else n_pass++;
  endtask
  task automatic test_random();
    int t0;
    logic stop;
    wave = {};
    add(1'b1, 4);
    for (int f = 0; f < 10; f++) begin
      stop = $urandom_range(0, 3) != 0;
      add_frame(8'($urandom), stop, t0);
      add(1'b1, stop ? $urandom_range(0, 12) : $urandom_range(1, 12));
    end
    add(1'b1, 6);
    model();
    play();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k])
        $display("FAIL rand_ev%0d: got %p required %p", k, obs_q[k], exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (obs_busy !== exp_busy || both !== 1'b0)
      $display("FAIL rand_busy: got busy=%0d both=%b required %0d 0", obs_busy, both, exp_busy);
    else n_pass++;
    n_checks++;
    if (rx_byte !== exp_byte) $display("FAIL rand_byte: got %h required %h", rx_byte, exp_byte);
    else n_pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_majority();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
